mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store request from the CPU MEM stage and sequences it into byte-wide read/write strobes toward the byte-addressed data memory.
- Handles byte, halfword and word accesses with little-endian byte order and sign or zero extension on loads.
- Reports misaligned and out-of-range accesses as errors without touching memory.

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the CPU MEM stage, the access controller and the byte-wide data memory.
// The controller uses the slave view; the surrounding environment uses the master view.
interface mem_access_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;
    logic        memread_o;
    logic        memwrite_o;
    logic [31:0] memaddr_o;
    logic [7:0]  writedata_o;
    logic [7:0]  memdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_signed_i,
               req_addr_i, req_wdata_i, memdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               busy_o, memread_o, memwrite_o, memaddr_o, writedata_o
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_signed_i,
               req_addr_i, req_wdata_i, memdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               busy_o, memread_o, memwrite_o, memaddr_o, writedata_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: splits one CPU access into little-endian byte beats toward
// the data memory and returns an extended load result or an error completion.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        err_flag;
    logic [1:0]  beat;
    logic [31:0] rd_buf;
    logic [31:0] rdata_q;

    logic [1:0]  req_last_beat;
    logic [1:0]  cap_last_beat;
    logic [32:0] req_end;
    logic        req_err;
    logic [31:0] rdata_final;

    // Index of the final beat: 0 for byte, 1 for half, 3 for word.
    function automatic logic [1:0] last_beat_of(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign req_last_beat = last_beat_of(bus.req_size_i);
    assign cap_last_beat = last_beat_of(cap_size);

    // 33-bit end address so a wrap past 2^32 is caught as out of range.
    assign req_end = {1'b0, bus.req_addr_i} + {31'b0, req_last_beat};

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size_i == 2'b11) begin
            req_err = 1'b1;
        end else if (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) begin
            req_err = 1'b1;
        end else if (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00) begin
            req_err = 1'b1;
        end else if (req_end >= 33'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        rdata_final = 32'h0;
        if (!cap_write && !err_flag) begin
            case (cap_size)
                2'b00:   rdata_final = cap_signed ? {{24{rd_buf[7]}}, rd_buf[7:0]}
                                                  : {24'h0, rd_buf[7:0]};
                2'b01:   rdata_final = cap_signed ? {{16{rd_buf[15]}}, rd_buf[15:0]}
                                                  : {16'h0, rd_buf[15:0]};
                default: rdata_final = rd_buf;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        bus.req_ready_o   = 1'b0;
        bus.busy_o        = 1'b0;
        bus.resp_valid_o  = 1'b0;
        bus.resp_err_o    = 1'b0;
        bus.resp_rdata_o  = rdata_q;
        bus.memread_o     = 1'b0;
        bus.memwrite_o    = 1'b0;
        bus.memaddr_o     = 32'h0;
        bus.writedata_o   = 8'h0;
        unique case (state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    state_next = req_err ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                bus.busy_o    = 1'b1;
                bus.memaddr_o = cap_addr + {30'b0, beat};
                if (cap_write) begin
                    bus.memwrite_o  = 1'b1;
                    bus.writedata_o = cap_wdata[{beat, 3'b000} +: 8];
                end else begin
                    bus.memread_o = 1'b1;
                end
                if (beat == cap_last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy_o       = 1'b1;
                bus.resp_valid_o = 1'b1;
                bus.resp_err_o   = err_flag;
                bus.resp_rdata_o = rdata_final;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, beat counting and load assembly; the response is held after DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_write  <= 1'b0;
            cap_size   <= 2'b00;
            cap_signed <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            err_flag   <= 1'b0;
            beat       <= 2'd0;
            rd_buf     <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        cap_write  <= bus.req_write_i;
                        cap_size   <= bus.req_size_i;
                        cap_signed <= bus.req_signed_i;
                        cap_addr   <= bus.req_addr_i;
                        cap_wdata  <= bus.req_wdata_i;
                        err_flag   <= req_err;
                        beat       <= 2'd0;
                        rd_buf     <= 32'h0;
                    end
                end
                ACCESS: begin
                    if (!cap_write) begin
                        rd_buf[{beat, 3'b000} +: 8] <= bus.memdata_i;
                    end
                    beat <= beat + 2'd1;
                end
                DONE: begin
                    rdata_q <= rdata_final;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a byte memory model on the bus plus a reference model
// built from address/size arithmetic, driven by directed and random requests.
module tb_mem_access_ctrl;

    localparam int MEM_BYTES = 32;

    logic clk      = 1'b0;
    logic rst_i    = 1'b1;
    logic mem_init = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 59 + 17) & 255);
    endfunction

    // Byte memory: combinational read, write committed at the clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
        end else if (bus.memwrite_o && bus.memaddr_o < 32'(MEM_BYTES)) begin
            mem[bus.memaddr_o[4:0]] <= bus.writedata_o;
        end
    end

    assign bus.memdata_i = (bus.memread_o && bus.memaddr_o < 32'(MEM_BYTES))
                         ? mem[bus.memaddr_o[4:0]] : 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        int     n;
        longint last;
        n = beats_of(size);
        if (n == 0) return 1'b1;
        if ((longint'(addr) % n) != 0) return 1'b1;
        last = longint'(addr) + n - 1;
        return last >= MEM_BYTES;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr);
        int     n;
        longint v;
        n = beats_of(size);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[int'(addr) + k]) << (8 * k);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // One full request: acceptance, every beat, the completion pulse and the held result.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        logic        exp_err;
        logic [31:0] exp_rdata;
        exp_err   = model_err(size, addr);
        n         = exp_err ? 0 : beats_of(size);
        exp_rdata = (exp_err || wr) ? 32'h0 : model_load(size, sgn, addr);

        @(posedge clk); #1;
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_size_i   = size;
        bus.req_signed_i = sgn;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(negedge clk);
        checkOutput("ready_idle", 32'(bus.req_ready_o), 32'd1);
        checkOutput("busy_idle", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;

        for (int k = 0; k < n; k++) begin
            bus.req_valid_i  = 1'($urandom);
            bus.req_write_i  = 1'($urandom);
            bus.req_size_i   = 2'($urandom);
            bus.req_signed_i = 1'($urandom);
            bus.req_addr_i   = $urandom;
            bus.req_wdata_i  = $urandom;
            @(negedge clk);
            checkOutput("beat_rd", 32'(bus.memread_o), 32'(!wr));
            checkOutput("beat_wr", 32'(bus.memwrite_o), 32'(wr));
            checkOutput("beat_addr", bus.memaddr_o, addr + 32'(k));
            checkOutput("beat_wdata", 32'(bus.writedata_o), wr ? 32'(8'(wdata >> (8 * k))) : 32'h0);
            checkOutput("beat_ready", 32'(bus.req_ready_o), 32'd0);
            checkOutput("beat_resp", 32'(bus.resp_valid_o), 32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;

        @(negedge clk);
        checkOutput("resp_valid", 32'(bus.resp_valid_o), 32'd1);
        checkOutput("resp_err", 32'(bus.resp_err_o), 32'(exp_err));
        checkOutput("resp_rdata", bus.resp_rdata_o, exp_rdata);
        checkOutput("done_strobes", {30'h0, bus.memread_o, bus.memwrite_o}, 32'h0);
        checkOutput("done_ready", 32'(bus.req_ready_o), 32'd0);
        if (!exp_err && wr) begin
            for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = 8'(wdata >> (8 * k));
        end

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("resp_pulse", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rdata_hold", bus.resp_rdata_o, exp_rdata);
        checkOutput("ready_after", 32'(bus.req_ready_o), 32'd1);

        for (int i = 0; i < 8 && bus.busy_o; i++) @(negedge clk);
        checkOutput("idle_after", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] old_top;
        old_top = ref_mem[int'(addr) + 3];
        @(posedge clk); #1;
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = 1'b1;
        bus.req_size_i   = 2'b10;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rst_beat_addr", bus.memaddr_o, addr + 32'(k));
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        @(negedge clk);
        checkOutput("rst_beat2_wr", 32'(bus.memwrite_o), 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_strobes", {30'h0, bus.memread_o, bus.memwrite_o}, 32'h0);
        checkOutput("rst_resp", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rst_rdata", bus.resp_rdata_o, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_no_resp", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rst_byte0", 32'(mem[int'(addr)]), 32'(wdata[7:0]));
        checkOutput("rst_byte1", 32'(mem[int'(addr) + 1]), 32'(wdata[15:8]));
        checkOutput("rst_byte3", 32'(mem[int'(addr) + 3]), 32'(old_top));
    endtask

    initial begin
        logic        wr;
        logic        sgn;
        logic [1:0]  size;
        logic [31:0] addr;

        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_size_i   = 2'b00;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        rst_i    = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_resp", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("reset_err", 32'(bus.resp_err_o), 32'd0);
        checkOutput("reset_rdata", bus.resp_rdata_o, 32'h0);
        checkOutput("reset_strobes", {30'h0, bus.memread_o, bus.memwrite_o}, 32'h0);
        checkOutput("reset_addr", bus.memaddr_o, 32'h0);
        checkOutput("reset_wdata", 32'(bus.writedata_o), 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd4,  32'hA1B2_C3D4);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd6,  32'h1234_5680);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'd6,  32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd6,  32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd2,  32'hDEAD_9234);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd2,  32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'd2,  32'h0);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd4,  32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd6,  32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd31, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd0,  32'h5555_AAAA);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd28, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd31, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd32, 32'h0);

        $display("[TB] random accesses");
        for (int t = 0; t < 60; t++) begin
            wr   = 1'($urandom);
            sgn  = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           addr = 32'($urandom_range(0, 35));
            applyStimulus(wr, size, sgn, addr, $urandom);
        end

        for (int i = 0; i < MEM_BYTES; i++) checkOutput("mem_image", 32'(mem[i]), 32'(ref_mem[i]));

        $display("[TB] reset during a word store");
        reset_mid_store(32'd24, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
